// File: rtl/sd_read_arbiter.sv
// ---------------------------------------------------------------------------
// sd_read_arbiter
//
// Two requesters share one SD-card block reader. Channel 0 is the MP3
// streaming path and channel 1 is the image/asset loader. The arbiter grants
// one channel at a time and latches that channel's block address. It drives
// the read strobe, follows the controller's busy flag through a complete
// read, and returns a one-cycle DONE or TIMEOUT_ERR pulse to the owner.
//
// State | Meaning
// ------+-------------------------------------------------------------------
// IDLE     | no read in flight; arbitrate when the card is ready
// ISSUE    | strobe asserted, waiting for SD_IS_READING to rise (timed)
// BUSY     | controller is reading; wait for SD_IS_READING to fall
// COMPLETE | one-cycle DONE pulse; guarantees an idle gap between reads
//
// Ports:
//   CLK                 system clock; all logic uses the rising edge
//   RESET               synchronous, active-high reset
//   SD_HAS_INITIALIZED  controller has finished card init
//   SD_IS_READING       controller is busy with a block read
//   REQ0 / ADDR0        channel 0 level request and block address
//   REQ1 / ADDR1        channel 1 level request and block address
//   SD_TO_READ          read strobe to the controller
//   SD_READ_ADDRESS     latched block address to the controller
//   GRANT0 / GRANT1     the named channel currently owns the reader
//   DONE0 / DONE1       one-cycle read-complete pulse to the owner
//   TIMEOUT_ERR         one-cycle pulse: the granted read never started
//   OWNER               index of the last or current granted channel
// ---------------------------------------------------------------------------
module sd_read_arbiter #(
    parameter int START_TIMEOUT = 1024,
    parameter int TO_W          = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SD_HAS_INITIALIZED,
    input  logic        SD_IS_READING,
    input  logic        REQ0,
    input  logic [31:0] ADDR0,
    input  logic        REQ1,
    input  logic [31:0] ADDR1,
    output logic        SD_TO_READ,
    output logic [31:0] SD_READ_ADDRESS,
    output logic        GRANT0,
    output logic        GRANT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        TIMEOUT_ERR,
    output logic        OWNER
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_BUSY     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;
    logic              busy_d;
    logic              rise;
    logic              fall;
    logic              winner;
    logic              can_arb;

    logic              to_read_nxt;
    logic [31:0]       addr_nxt;
    logic              grant0_nxt;
    logic              grant1_nxt;
    logic              done0_nxt;
    logic              done1_nxt;
    logic              to_err_nxt;
    logic              owner_nxt;

    // Busy edges are taken against a registered copy of the controller flag.
    assign rise = SD_IS_READING & ~busy_d;
    assign fall = ~SD_IS_READING & busy_d;

    // A lone request wins outright; on a tie the channel that did not own
    // the reader last time wins. OWNER resets to 1 so channel 0 takes the
    // first tie.
    always_comb begin
        winner = 1'b0;
        if (REQ0 && REQ1) begin
            winner = ~OWNER;
        end else if (REQ1) begin
            winner = 1'b1;
        end
    end

    assign can_arb = SD_HAS_INITIALIZED & ~SD_IS_READING & (REQ0 | REQ1);

    always_comb begin
        state_nxt   = state;
        to_cnt_nxt  = to_cnt;
        to_read_nxt = SD_TO_READ;
        addr_nxt    = SD_READ_ADDRESS;
        grant0_nxt  = GRANT0;
        grant1_nxt  = GRANT1;
        done0_nxt   = 1'b0;
        done1_nxt   = 1'b0;
        to_err_nxt  = 1'b0;
        owner_nxt   = OWNER;

        case (state)
            S_IDLE: begin
                if (can_arb) begin
                    owner_nxt   = winner;
                    addr_nxt    = winner ? ADDR1 : ADDR0;
                    grant0_nxt  = ~winner;
                    grant1_nxt  = winner;
                    to_read_nxt = 1'b1;
                    to_cnt_nxt  = '0;
                    state_nxt   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                to_cnt_nxt = to_cnt + 1'b1;
                // A rise on the terminal-count cycle still counts as a start.
                if (rise) begin
                    state_nxt = S_BUSY;
                end else if (to_cnt == TO_LAST) begin
                    to_read_nxt = 1'b0;
                    grant0_nxt  = 1'b0;
                    grant1_nxt  = 1'b0;
                    to_err_nxt  = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end

            S_BUSY: begin
                if (fall) begin
                    to_read_nxt = 1'b0;
                    grant0_nxt  = 1'b0;
                    grant1_nxt  = 1'b0;
                    done0_nxt   = GRANT0;
                    done1_nxt   = GRANT1;
                    state_nxt   = S_COMPLETE;
                end
            end

            S_COMPLETE: begin
                // No arbitration here: forces one idle cycle between reads.
                state_nxt = S_IDLE;
            end

            default: begin
                to_read_nxt = 1'b0;
                grant0_nxt  = 1'b0;
                grant1_nxt  = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= S_IDLE;
            to_cnt          <= '0;
            busy_d          <= 1'b0;
            SD_TO_READ      <= 1'b0;
            SD_READ_ADDRESS <= 32'd0;
            GRANT0          <= 1'b0;
            GRANT1          <= 1'b0;
            DONE0           <= 1'b0;
            DONE1           <= 1'b0;
            TIMEOUT_ERR     <= 1'b0;
            OWNER           <= 1'b1;
        end else begin
            state           <= state_nxt;
            to_cnt          <= to_cnt_nxt;
            busy_d          <= SD_IS_READING;
            SD_TO_READ      <= to_read_nxt;
            SD_READ_ADDRESS <= addr_nxt;
            GRANT0          <= grant0_nxt;
            GRANT1          <= grant1_nxt;
            DONE0           <= done0_nxt;
            DONE1           <= done1_nxt;
            TIMEOUT_ERR     <= to_err_nxt;
            OWNER           <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_read_arbiter
//
// Directed bench for sd_read_arbiter with START_TIMEOUT = 8. Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sd_read_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SD_HAS_INITIALIZED = 1'b0;
    logic        SD_IS_READING = 1'b0;
    logic        REQ0 = 1'b0;
    logic [31:0] ADDR0 = 32'd0;
    logic        REQ1 = 1'b0;
    logic [31:0] ADDR1 = 32'd0;
    logic        SD_TO_READ;
    logic [31:0] SD_READ_ADDRESS;
    logic        GRANT0;
    logic        GRANT1;
    logic        DONE0;
    logic        DONE1;
    logic        TIMEOUT_ERR;
    logic        OWNER;

    int checks = 0;
    int errors = 0;
    bit run_mon = 1'b0;

    sd_read_arbiter #(
        .START_TIMEOUT(8),
        .TO_W(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SD_HAS_INITIALIZED(SD_HAS_INITIALIZED),
        .SD_IS_READING(SD_IS_READING),
        .REQ0(REQ0),
        .ADDR0(ADDR0),
        .REQ1(REQ1),
        .ADDR1(ADDR1),
        .SD_TO_READ(SD_TO_READ),
        .SD_READ_ADDRESS(SD_READ_ADDRESS),
        .GRANT0(GRANT0),
        .GRANT1(GRANT1),
        .DONE0(DONE0),
        .DONE1(DONE1),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        SD_IS_READING = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Invariants checked on the falling edge for the whole run.
    always @(negedge CLK) begin
        if (run_mon && !RESET) begin
            assert (!(GRANT0 && GRANT1)) else begin
                errors++;
                $error("FAIL inv_grant: observed g0=%0b g1=%0b expected at most one", GRANT0, GRANT1);
            end
            assert ((32'(DONE0) + 32'(DONE1) + 32'(TIMEOUT_ERR)) <= 32'd1) else begin
                errors++;
                $error("FAIL inv_pulse: observed d0=%0b d1=%0b to=%0b expected exclusive", DONE0, DONE1, TIMEOUT_ERR);
            end
        end
    end

    // One tie-mode read: grant on the next edge, immediate start, short busy.
    task automatic emul_read(input logic ch, input logic [31:0] addr);
        tick();
        check("tie_grant0", {31'd0, GRANT0}, {31'd0, ~ch});
        check("tie_grant1", {31'd0, GRANT1}, {31'd0, ch});
        check("tie_addr", SD_READ_ADDRESS, addr);
        check("tie_owner", {31'd0, OWNER}, {31'd0, ch});
        check("tie_strobe", {31'd0, SD_TO_READ}, 32'd1);
        SD_IS_READING = 1'b1;
        tick();
        tick();
        tick();
        SD_IS_READING = 1'b0;
        tick();
        check("tie_done0", {31'd0, DONE0}, {31'd0, ~ch});
        check("tie_done1", {31'd0, DONE1}, {31'd0, ch});
        check("tie_strobe_off", {31'd0, SD_TO_READ}, 32'd0);
        tick();
        check("tie_gap_strobe", {31'd0, SD_TO_READ}, 32'd0);
        check("tie_gap_grant", {30'd0, GRANT1, GRANT0}, 32'd0);
    endtask

    int  hi_cnt;
    bit  early_to;
    bit  any_grant;
    bit  any_done;

    initial begin
        // ---------------- reset values ----------------
        do_reset();
        run_mon = 1'b1;
        check("rst_strobe", {31'd0, SD_TO_READ}, 32'd0);
        check("rst_addr", SD_READ_ADDRESS, 32'd0);
        check("rst_grants", {30'd0, GRANT1, GRANT0}, 32'd0);
        check("rst_pulses", {29'd0, TIMEOUT_ERR, DONE1, DONE0}, 32'd0);
        check("rst_owner", {31'd0, OWNER}, 32'd1);

        // ---------------- single request ----------------
        SD_HAS_INITIALIZED = 1'b1;
        REQ0 = 1'b1;
        ADDR0 = 32'h100;
        tick();
        check("single_strobe", {31'd0, SD_TO_READ}, 32'd1);
        check("single_grant0", {31'd0, GRANT0}, 32'd1);
        check("single_addr", SD_READ_ADDRESS, 32'h100);
        check("single_owner", {31'd0, OWNER}, 32'd0);
        REQ0 = 1'b0;
        tick();
        tick();
        SD_IS_READING = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE0 || DONE1) any_done = 1'b1;
        end
        check("single_busy_strobe", {31'd0, SD_TO_READ}, 32'd1);
        check("single_no_early_done", {31'd0, any_done}, 32'd0);
        SD_IS_READING = 1'b0;
        tick();
        check("single_done0", {31'd0, DONE0}, 32'd1);
        check("single_grant_off", {31'd0, GRANT0}, 32'd0);
        tick();
        check("single_done0_end", {31'd0, DONE0}, 32'd0);
        any_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (GRANT0 || SD_TO_READ) any_grant = 1'b1;
        end
        check("single_stay_idle", {31'd0, any_grant}, 32'd0);

        // ---------------- tie round-robin ----------------
        do_reset();
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        ADDR0 = 32'h10;
        ADDR1 = 32'h20;
        emul_read(1'b0, 32'h10);
        emul_read(1'b1, 32'h20);
        emul_read(1'b0, 32'h10);
        emul_read(1'b1, 32'h20);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();

        // ---------------- timeout ----------------
        do_reset();
        REQ1 = 1'b1;
        ADDR1 = 32'h55;
        tick();
        check("to_grant1", {31'd0, GRANT1}, 32'd1);
        REQ1 = 1'b0;
        hi_cnt = 1;
        early_to = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (SD_TO_READ !== 1'b1) break;
            if (TIMEOUT_ERR) early_to = 1'b1;
            hi_cnt++;
        end
        check("to_strobe_cycles", 32'(hi_cnt), 32'd8);
        check("to_no_early_err", {31'd0, early_to}, 32'd0);
        check("to_err_pulse", {31'd0, TIMEOUT_ERR}, 32'd1);
        check("to_no_done", {30'd0, DONE1, DONE0}, 32'd0);
        check("to_grant_off", {31'd0, GRANT1}, 32'd0);
        check("to_owner", {31'd0, OWNER}, 32'd1);
        tick();
        check("to_err_end", {31'd0, TIMEOUT_ERR}, 32'd0);
        check("to_no_done_after", {30'd0, DONE1, DONE0}, 32'd0);

        // ---------------- rise on terminal count ----------------
        REQ0 = 1'b1;
        ADDR0 = 32'h77;
        tick();
        check("tc_grant0", {31'd0, GRANT0}, 32'd1);
        REQ0 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        SD_IS_READING = 1'b1;
        tick();
        check("tc_rise_strobe", {31'd0, SD_TO_READ}, 32'd1);
        check("tc_rise_no_err", {31'd0, TIMEOUT_ERR}, 32'd0);
        tick();
        tick();
        check("tc_still_busy", {31'd0, GRANT0}, 32'd1);
        SD_IS_READING = 1'b0;
        tick();
        check("tc_done0", {31'd0, DONE0}, 32'd1);
        tick();

        // ---------------- init gating + latch/withdraw ----------------
        do_reset();
        SD_HAS_INITIALIZED = 1'b0;
        REQ0 = 1'b1;
        ADDR0 = 32'h200;
        any_grant = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (GRANT0 || GRANT1 || SD_TO_READ) any_grant = 1'b1;
        end
        check("gate_no_grant", {31'd0, any_grant}, 32'd0);
        SD_HAS_INITIALIZED = 1'b1;
        tick();
        check("gate_grant0", {31'd0, GRANT0}, 32'd1);
        check("gate_addr", SD_READ_ADDRESS, 32'h200);
        SD_IS_READING = 1'b1;
        tick();
        ADDR0 = 32'h999;
        REQ0 = 1'b0;
        tick();
        tick();
        check("latch_addr", SD_READ_ADDRESS, 32'h200);
        check("latch_grant", {31'd0, GRANT0}, 32'd1);
        SD_IS_READING = 1'b0;
        tick();
        check("latch_done0", {31'd0, DONE0}, 32'd1);
        check("latch_addr_end", SD_READ_ADDRESS, 32'h200);
        tick();

        // ---------------- reset mid-BUSY ----------------
        REQ0 = 1'b1;
        ADDR0 = 32'h300;
        tick();
        check("rb_owner0", {31'd0, OWNER}, 32'd0);
        REQ0 = 1'b0;
        SD_IS_READING = 1'b1;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        check("rb_strobe", {31'd0, SD_TO_READ}, 32'd0);
        check("rb_addr", SD_READ_ADDRESS, 32'd0);
        check("rb_grants", {30'd0, GRANT1, GRANT0}, 32'd0);
        check("rb_pulses", {29'd0, TIMEOUT_ERR, DONE1, DONE0}, 32'd0);
        check("rb_owner", {31'd0, OWNER}, 32'd1);
        RESET = 1'b0;
        SD_IS_READING = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (DONE0 || DONE1 || TIMEOUT_ERR || SD_TO_READ) any_done = 1'b1;
        end
        check("rb_quiet_after", {31'd0, any_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
